// File: rtl/char_pkg.sv
// char_pkg: shared constants and types for the character-match collector.
//   N_CHAR   character slots per plate
//   IDX_W    template index width
//   DIFF_W   difference width
//   IDX_NONE index reported for a slot with no matching template
//   DIFF_MAX all-ones difference (also the "no match" difference)
package char_pkg;

  localparam int unsigned N_CHAR = 7;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DIFF_W = 16;
  localparam int unsigned POS_W  = 3;

  localparam logic [IDX_W-1:0]  IDX_NONE = 4'hA;
  localparam logic [DIFF_W-1:0] DIFF_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DIFF_W-1:0] diff;
  } slot_t;

  localparam slot_t SLOT_INIT = '{idx: IDX_NONE, diff: DIFF_MAX};

endpackage

// File: rtl/char_match_pack_if.sv
// char_match_pack_if: per-template difference stream feeding char_match_pack.
//   frame_start  plate start pulse (clears all slots)
//   frame_end    plate complete pulse
//   diff_valid   qualifies diff_in / tmpl_idx / char_pos / char_last
//   diff_in      difference of current template vs. current character
//   tmpl_idx     template index of this beat
//   char_pos     character slot of this beat
//   char_last    last template beat for char_pos
//   max_diff     rejection threshold (present only with CHAR_MATCH_THRESH_EN)
// master drives the stream, slave (char_match_pack) consumes it.
interface char_match_pack_if;
  import char_pkg::*;

  logic              frame_start;
  logic              frame_end;
  logic              diff_valid;
  logic [DIFF_W-1:0] diff_in;
  logic [IDX_W-1:0]  tmpl_idx;
  logic [POS_W-1:0]  char_pos;
  logic              char_last;
`ifdef CHAR_MATCH_THRESH_EN
  logic [DIFF_W-1:0] max_diff;

  modport master (
    output frame_start, frame_end, diff_valid, diff_in, tmpl_idx,
           char_pos, char_last, max_diff
  );
  modport slave (
    input  frame_start, frame_end, diff_valid, diff_in, tmpl_idx,
           char_pos, char_last, max_diff
  );
`else
  modport master (
    output frame_start, frame_end, diff_valid, diff_in, tmpl_idx,
           char_pos, char_last
  );
  modport slave (
    input  frame_start, frame_end, diff_valid, diff_in, tmpl_idx,
           char_pos, char_last
  );
`endif

endinterface

// File: rtl/char_argmin.sv
// char_argmin: running minimum of the difference stream for one character.
//   clk, rst   clock, asynchronous active-high reset
//   clr        re-initialise the running minimum (applied before this beat)
//   vld        beat qualifier
//   last       final beat of this character (included in the result)
//   diff, idx  difference and template index of the beat
//   best_idx   index of the minimum including the current beat
//   best_diff  minimum difference including the current beat
//   done       vld && last: best_* is the finished result for the character
module char_argmin
  import char_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              vld,
  input  logic              last,
  input  logic [DIFF_W-1:0] diff,
  input  logic [IDX_W-1:0]  idx,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DIFF_W-1:0] best_diff,
  output logic              done
);

  logic [DIFF_W-1:0] min_q, min_d, base_diff;
  logic [IDX_W-1:0]  idx_q, idx_d, base_idx;
  logic              take;

  always_comb begin
    base_diff = clr ? DIFF_MAX : min_q;
    base_idx  = clr ? IDX_NONE : idx_q;
    // Strict compare: ties keep the earlier index, all-ones never loads.
    take      = vld && (diff < base_diff);
    best_diff = take ? diff : base_diff;
    best_idx  = take ? idx  : base_idx;
    done      = vld && last;

    min_d = base_diff;
    idx_d = base_idx;
    if (vld && last) begin
      min_d = DIFF_MAX;
      idx_d = IDX_NONE;
    end else if (vld) begin
      min_d = best_diff;
      idx_d = best_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= DIFF_MAX;
      idx_q <= IDX_NONE;
    end else begin
      min_q <= min_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/char_match_pack.sv
// char_match_pack: collects per-character best template matches for a plate
// and emits them as one packed vector with a single-cycle strobe.
//   clk, rst      clock, asynchronous active-high reset
//   bus           char_match_pack_if.slave difference stream
//   char_index_c  packed best indices, slot 0 at [IDX_W-1:0]
//   char_diff_c   packed best differences, slot 0 at [DIFF_W-1:0]
//   char_valid_c  one-cycle result strobe (cycle after frame_end)
//   err_o         sticky: a beat arrived with char_pos >= N_CHAR
// Optional feature macro CHAR_MATCH_THRESH_EN: a slot whose best difference
// exceeds bus.max_diff reports IDX_NONE (difference still reported).
module char_match_pack
  import char_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  char_match_pack_if.slave         bus,
  output logic [N_CHAR*IDX_W-1:0]  char_index_c,
  output logic [N_CHAR*DIFF_W-1:0] char_diff_c,
  output logic                     char_valid_c,
  output logic                     err_o
);

  state_t                    state_q, state_d;
  slot_t [N_CHAR-1:0]        slot_q, slot_d;
  logic [N_CHAR*IDX_W-1:0]   index_q, index_d;
  logic [N_CHAR*DIFF_W-1:0]  diff_q, diff_d;
  logic                      valid_q, err_q;

  logic              accept, pos_ok, beat, bad, emit;
  logic [IDX_W-1:0]  best_idx, wr_idx;
  logic [DIFF_W-1:0] best_diff;
  logic              am_done;

  // A beat coinciding with frame_start belongs to the new frame, so it is
  // accepted even when the FSM is not yet in SCAN.
  assign accept = bus.diff_valid && ((state_q == SCAN) || bus.frame_start);
  assign pos_ok = 32'(bus.char_pos) < N_CHAR;
  assign beat   = accept && pos_ok;
  assign bad    = accept && !pos_ok;
  assign emit   = (state_q == SCAN) && bus.frame_end;

  char_argmin u_argmin (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.frame_start),
    .vld       (beat),
    .last      (bus.char_last),
    .diff      (bus.diff_in),
    .idx       (bus.tmpl_idx),
    .best_idx  (best_idx),
    .best_diff (best_diff),
    .done      (am_done)
  );

`ifdef CHAR_MATCH_THRESH_EN
  assign wr_idx = (best_diff > bus.max_diff) ? IDX_NONE : best_idx;
`else
  assign wr_idx = best_idx;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.frame_start) state_d = SCAN;
      SCAN: if (bus.frame_end)   state_d = EMIT;
      EMIT: state_d = bus.frame_start ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear first, then the finishing beat writes; emit samples the result so
  // a char_last coinciding with frame_end lands in the output.
  always_comb begin
    slot_d = slot_q;
    if (bus.frame_start) slot_d = {N_CHAR{SLOT_INIT}};
    for (int unsigned i = 0; i < N_CHAR; i++) begin
      if (am_done && (32'(bus.char_pos) == i)) begin
        slot_d[i].idx  = wr_idx;
        slot_d[i].diff = best_diff;
      end
    end
    index_d = '0;
    diff_d  = '0;
    for (int unsigned i = 0; i < N_CHAR; i++) begin
      index_d[i*IDX_W +: IDX_W]   = slot_d[i].idx;
      diff_d[i*DIFF_W +: DIFF_W]  = slot_d[i].diff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= {N_CHAR{SLOT_INIT}};
      index_q <= {N_CHAR{IDX_NONE}};
      diff_q  <= '1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      valid_q <= emit;
      err_q   <= err_q | bad;
      if (emit) begin
        index_q <= index_d;
        diff_q  <= diff_d;
      end
    end
  end

  assign char_index_c = index_q;
  assign char_diff_c  = diff_q;
  assign char_valid_c = valid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_char_match_pack.sv
// tb_char_match_pack: directed bench for char_match_pack with a scoreboard of
// expected emitted vectors, compared whenever char_valid_c is observed.
module tb_char_match_pack;
  import char_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  char_match_pack_if bus ();

  logic [N_CHAR*IDX_W-1:0]  char_index_c;
  logic [N_CHAR*DIFF_W-1:0] char_diff_c;
  logic                     char_valid_c;
  logic                     err_o;

  char_match_pack dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .char_index_c (char_index_c),
    .char_diff_c  (char_diff_c),
    .char_valid_c (char_valid_c),
    .err_o        (err_o)
  );

  typedef struct {
    logic [N_CHAR*IDX_W-1:0]  idx;
    logic [N_CHAR*DIFF_W-1:0] diff;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  logic [IDX_W-1:0]  e_idx  [N_CHAR];
  logic [DIFF_W-1:0] e_diff [N_CHAR];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe must have a queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && char_valid_c === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 128'd1, 128'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("emit_index", 128'(char_index_c), 128'(mon_e.idx));
        chk("emit_diff", 128'(char_diff_c), 128'(mon_e.diff));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.diff_valid  = 1'b0;
    bus.diff_in     = '0;
    bus.tmpl_idx    = '0;
    bus.char_pos    = '0;
    bus.char_last   = 1'b0;
  endtask

  // frame_start / frame_end may be preset by the caller for same-cycle events.
  task automatic beat(input int unsigned pos, input int unsigned idx,
                      input int unsigned diff, input int unsigned last);
    bus.diff_valid = 1'b1;
    bus.char_pos   = 3'(pos);
    bus.tmpl_idx   = 4'(idx);
    bus.diff_in    = 16'(diff);
    bus.char_last  = 1'(last);
    cyc();
    clear_inputs();
  endtask

  task automatic pulse_start();
    bus.frame_start = 1'b1;
    cyc();
    clear_inputs();
  endtask

  task automatic pulse_end();
    bus.frame_end = 1'b1;
    cyc();
    clear_inputs();
  endtask

  task automatic exp_clear();
    for (int i = 0; i < int'(N_CHAR); i++) begin
      e_idx[i]  = 4'hA;
      e_diff[i] = 16'hFFFF;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.idx  = '0;
    e.diff = '0;
    for (int i = 0; i < int'(N_CHAR); i++) begin
      e.idx[i*4 +: 4]    = e_idx[i];
      e.diff[i*16 +: 16] = e_diff[i];
    end
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 8 && sb.size() != 0; n++) @(negedge clk);
    chk(tag, 128'(sb.size()), 128'd0);
  endtask

  // Template k == pos is the good match (0x10), the others 0xF0.
  task automatic plate(input int unsigned n_pos);
    for (int unsigned p = 0; p < n_pos; p++) begin
      for (int unsigned k = 0; k < 10; k++)
        beat(p, k, (k == p) ? 32'h10 : 32'hF0, (k == 9) ? 1 : 0);
      e_idx[p]  = 4'(p);
      e_diff[p] = 16'h0010;
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
`ifdef CHAR_MATCH_THRESH_EN
    bus.max_diff = 16'd30;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_index", 128'(char_index_c), 128'(28'hAAAAAAA));
    chk("reset_diff", 128'(char_diff_c), {16'h0, {7{16'hFFFF}}});
    chk("reset_valid", 128'(char_valid_c), 128'd0);
    chk("reset_err", 128'(err_o), 128'd0);
    rst = 1'b0;
    cyc();

    // Full plate.
    exp_clear();
    pulse_start();
    plate(7);
    push_exp();
    pulse_end();
    chk("full_valid_hi", 128'(char_valid_c), 128'd1);
    cyc();
    chk("full_valid_lo", 128'(char_valid_c), 128'd0);
    chk("full_index_hold", 128'(char_index_c), 128'(28'h6543210));
    chk("full_diff_hold", 128'(char_diff_c), 128'({7{16'h0010}}));
    wait_drain("full_drain");

    // Partial plate; slot 5 has a pending character with no char_last.
    exp_clear();
    pulse_start();
    plate(5);
    beat(5, 3, 32'h01, 0);
    push_exp();
    pulse_end();
    chk("partial_valid_hi", 128'(char_valid_c), 128'd1);
    cyc();
    chk("partial_valid_lo", 128'(char_valid_c), 128'd0);
    wait_drain("partial_drain");

    // Tie keeps earlier index; all-ones never matches.
    exp_clear();
    pulse_start();
    beat(0, 3, 32'h20, 0);
    beat(0, 7, 32'h20, 1);
    beat(1, 0, 32'hFFFF, 0);
    beat(1, 1, 32'hFFFF, 0);
    beat(1, 2, 32'hFFFF, 1);
    e_idx[0] = 4'h3; e_diff[0] = 16'h0020;
    e_idx[1] = 4'hA; e_diff[1] = 16'hFFFF;
    push_exp();
    pulse_end();
    wait_drain("tie_drain");

    // frame_start with first beat; frame_end with final char_last;
    // frame_start in EMIT with a beat, then a second plate.
    exp_clear();
    bus.frame_start = 1'b1;
    beat(2, 4, 32'h05, 0);
    beat(2, 6, 32'h11, 1);
    beat(4, 1, 32'h40, 0);
    e_idx[2] = 4'h4; e_diff[2] = 16'h0005;
    e_idx[4] = 4'h2; e_diff[4] = 16'h0008;
    push_exp();
    bus.frame_end = 1'b1;
    beat(4, 2, 32'h08, 1);
    exp_clear();
    bus.frame_start = 1'b1;
    beat(3, 5, 32'h01, 0);
    beat(3, 8, 32'h02, 1);
    e_idx[3] = 4'h5; e_diff[3] = 16'h0001;
    push_exp();
    pulse_end();
    wait_drain("simul_drain");

    // Out-of-range position outside SCAN is ignored entirely.
    beat(7, 1, 32'h01, 1);
    chk("err_idle", 128'(err_o), 128'd0);

    // Out-of-range position in SCAN; slot rewrite, last write wins.
    exp_clear();
    pulse_start();
    beat(7, 1, 32'h01, 1);
    chk("err_set", 128'(err_o), 128'd1);
    beat(0, 2, 32'h05, 1);
    beat(0, 4, 32'h09, 1);
    repeat (3) cyc();
    chk("err_sticky", 128'(err_o), 128'd1);
    e_idx[0] = 4'h4; e_diff[0] = 16'h0009;
    push_exp();
    pulse_end();
    wait_drain("err_drain");
    chk("err_after_frame", 128'(err_o), 128'd1);

`ifdef CHAR_MATCH_THRESH_EN
    exp_clear();
    pulse_start();
    beat(0, 1, 32'h50, 1);
    beat(1, 2, 32'h10, 0);
    beat(1, 3, 32'h60, 1);
    e_idx[0] = 4'hA; e_diff[0] = 16'h0050;
    e_idx[1] = 4'h2; e_diff[1] = 16'h0010;
    push_exp();
    pulse_end();
    wait_drain("thresh_drain");
`endif

    // Reset mid-SCAN: no strobe, outputs back to reset values.
    pulse_start();
    beat(1, 1, 32'h02, 0);
    beat(1, 2, 32'h01, 1);
    rst = 1'b1;
    cyc();
    chk("rst_index", 128'(char_index_c), 128'(28'hAAAAAAA));
    chk("rst_diff", 128'(char_diff_c), {16'h0, {7{16'hFFFF}}});
    chk("rst_valid", 128'(char_valid_c), 128'd0);
    chk("rst_err", 128'(err_o), 128'd0);
    rst = 1'b0;
    cyc();
    pulse_end();
    chk("idle_end_valid", 128'(char_valid_c), 128'd0);
    repeat (3) cyc();
    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
